// File: rtl/xprop_rr_sched.sv
// xprop_rr_sched
//   Round-robin scheduler in front of one X-aware masking datapath.
//   The winning requester's data has its low W-1 bits ANDed with its enable,
//   and its MSB passes through unmasked. A result that still contains any
//   unknown bit is replaced by all-X and flagged. The result goes into a
//   one-entry output register with a valid/ready handshake.
//
//   Optional feature macro: XPROP_RR_STICKY_POISON_EN
//     When defined, a requester that has produced one poisoned result keeps
//     poisoning every later result until reset.
//
// Ports
//   i_clk            rising-edge clock
//   i_rst_n          asynchronous active-low reset
//   i_req_valid      [NREQ]    per-requester valid (only a clean 1 is eligible)
//   i_req_en         [NREQ]    per-requester mask enable
//   i_req_data       [NREQ*W]  requester i at [i*W +: W]
//   o_req_ready      [NREQ]    one-hot accept, combinational
//   o_out_valid                output register holds a result
//   i_out_ready                consumer takes the result (X counts as 0)
//   o_out_data       [W]       masked result, all-X when poisoned
//   o_out_grant      [IDXW]    requester that produced o_out_data
//   o_out_unknown              result was poisoned
//   o_x_valid_seen             sticky: some i_req_valid bit was X/Z
module xprop_rr_sched #(
  parameter  int NREQ = 4,
  parameter  int W    = 4,
  localparam int IDXW = $clog2(NREQ)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [NREQ-1:0]   i_req_valid,
  input  logic [NREQ-1:0]   i_req_en,
  input  logic [NREQ*W-1:0] i_req_data,
  output logic [NREQ-1:0]   o_req_ready,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [W-1:0]      o_out_data,
  output logic [IDXW-1:0]   o_out_grant,
  output logic              o_out_unknown,
  output logic              o_x_valid_seen
);

  logic [IDXW-1:0] r_ptr;
  logic            r_out_valid;
  logic [W-1:0]    r_out_data;
  logic [IDXW-1:0] r_out_grant;
  logic            r_out_unknown;
  logic            r_xseen;

  logic [NREQ-1:0] w_elig;
  logic            w_found;
  logic [IDXW-1:0] w_gnt;
  logic [IDXW:0]   w_idx;
  logic            w_can_accept;
  logic            w_accept;
  logic [W-1:0]    w_sel;
  logic [W-1:0]    w_result;
  logic            w_poison;
  logic [IDXW-1:0] w_ptr_nxt;

  // Only a clean 1 makes a requester eligible; X/Z valid is never granted.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NREQ; i++) w_elig[i] = (i_req_valid[i] === 1'b1);
  end

  // Scan upward from the pointer with wrap; first eligible wins.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = {1'b0, r_ptr} + (IDXW+1)'(k);
      if (w_idx >= (IDXW+1)'(NREQ)) w_idx = w_idx - (IDXW+1)'(NREQ);
      if (!w_found && w_elig[w_idx[IDXW-1:0]]) begin
        w_found = 1'b1;
        w_gnt   = w_idx[IDXW-1:0];
      end
    end
  end

  // An unknown out_ready must stall, so compare against a clean 1.
  assign w_can_accept = i_rst_n && (!r_out_valid || (i_out_ready === 1'b1));
  assign w_accept     = w_found && w_can_accept;

  always_comb begin
    o_req_ready = '0;
    if (w_accept) o_req_ready[w_gnt] = 1'b1;
  end

  assign w_sel    = i_req_data[int'(w_gnt)*W +: W];
  assign w_result = {w_sel[W-1], w_sel[W-2:0] & {(W-1){i_req_en[w_gnt]}}};
  assign w_ptr_nxt = (w_gnt == IDXW'(NREQ-1)) ? '0 : w_gnt + 1'b1;

`ifdef XPROP_RR_STICKY_POISON_EN
  logic [NREQ-1:0] r_sticky;

  assign w_poison = $isunknown(w_result) || r_sticky[w_gnt];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                 r_sticky <= '0;
    else if (w_accept && w_poison) r_sticky[w_gnt] <= 1'b1;
  end
`else
  assign w_poison = $isunknown(w_result);
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr         <= '0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_grant   <= '0;
      r_out_unknown <= 1'b0;
    end else if (w_accept) begin
      // Covers simultaneous drain+accept: the register is simply replaced.
      r_ptr         <= w_ptr_nxt;
      r_out_valid   <= 1'b1;
      r_out_data    <= w_poison ? {W{1'bx}} : w_result;
      r_out_grant   <= w_gnt;
      r_out_unknown <= w_poison;
    end else if (r_out_valid && (i_out_ready === 1'b1)) begin
      r_out_valid   <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_xseen <= 1'b0;
    else          r_xseen <= r_xseen | $isunknown(i_req_valid);
  end

  assign o_out_valid    = r_out_valid;
  assign o_out_data     = r_out_data;
  assign o_out_grant    = r_out_grant;
  assign o_out_unknown  = r_out_unknown;
  assign o_x_valid_seen = r_xseen;

endmodule

// File: tb/tb_xprop_rr_sched.sv
module tb_xprop_rr_sched;
  localparam int NREQ = 4;
  localparam int W    = 4;
  localparam int IDXW = $clog2(NREQ);

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   valid, en, rdy;
  logic [NREQ*W-1:0] data;
  logic              out_ready, o_valid, o_unknown, o_xseen;
  logic [W-1:0]      o_data;
  logic [IDXW-1:0]   o_grant;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int              m_ptr;
  logic            m_valid, m_unknown, m_xseen;
  logic [W-1:0]    m_data;
  logic [IDXW-1:0] m_grant;
  bit   [NREQ-1:0] m_sticky;

  always #5 clk = ~clk;

  xprop_rr_sched #(.NREQ(NREQ), .W(W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(valid), .i_req_en(en),
    .i_req_data(data), .o_req_ready(rdy), .o_out_valid(o_valid),
    .i_out_ready(out_ready), .o_out_data(o_data), .o_out_grant(o_grant),
    .o_out_unknown(o_unknown), .o_x_valid_seen(o_xseen));

  // first requester at or after the pointer (mod NREQ) whose valid is a clean 1
  function automatic int pick();
    for (int k = 0; k < NREQ; k++)
      if (valid[(m_ptr + k) % NREQ] === 1'b1) return (m_ptr + k) % NREQ;
    return -1;
  endfunction

  function automatic bit can_take();
    return !m_valid || (out_ready === 1'b1);
  endfunction

  function automatic logic [NREQ-1:0] exp_ready();
    logic [NREQ-1:0] r;
    int g;
    r = '0;
    g = pick();
    if (g >= 0 && can_take()) r[g] = 1'b1;
    return r;
  endfunction

  // advance the model by one clock edge, then move to 1 time unit past it
  task automatic tick();
    int g;
    logic [W-1:0] d, res;
    bit poison;
    g = pick();
    if (g >= 0 && can_take()) begin
      d = data[g*W +: W];
      res = d;
      for (int b = 0; b < W-1; b++) res[b] = d[b] & en[g];
      poison = $isunknown(res);
`ifdef XPROP_RR_STICKY_POISON_EN
      poison = poison || m_sticky[g];
      if (poison) m_sticky[g] = 1'b1;
`endif
      m_data    = poison ? {W{1'bx}} : res;
      m_unknown = poison;
      m_grant   = IDXW'(g);
      m_valid   = 1'b1;
      m_ptr     = (g + 1) % NREQ;
    end else if (m_valid && out_ready === 1'b1) begin
      m_valid = 1'b0;
    end
    m_xseen = m_xseen | $isunknown(valid);
    @(posedge clk);
    #1;
  endtask

  // async reset; checks the immediate reset state, releases at a negedge
  task automatic test_reset();
    rst_n = 1'b0; valid = '0; en = '0; data = '0; out_ready = 1'b0;
    #2;
    n_tests++;
    if ({o_valid, o_data, o_grant, o_unknown, o_xseen, rdy} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b d=%h g=%0d u=%b xs=%b rdy=%b, want all 0",
               o_valid, o_data, o_grant, o_unknown, o_xseen, rdy);
    end
    m_ptr = 0; m_valid = 0; m_data = '0; m_grant = '0; m_unknown = 0; m_xseen = 0;
    m_sticky = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_idle();
    for (int c = 0; c < 4; c++) begin
      valid = '0; out_ready = c[0];
      #2;
      n_tests++;
      if (rdy !== '0 || {o_valid, o_data} !== '0) begin
        n_fail++;
        $display("FAIL idle: got rdy=%b v=%b d=%h, want 0 0 0", rdy, o_valid, o_data);
      end
      tick();
    end
  endtask

  task automatic test_rr();
    valid = '1; en = '1; data = '1; out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #2;
      n_tests++;
      if (rdy !== exp_ready()) begin
        n_fail++; $display("FAIL rr_ready c%0d: got %b want %b", c, rdy, exp_ready());
      end
      tick();
      n_tests++;
      if ({o_valid, o_data, o_grant, o_unknown} !== {1'b1, 4'hF, IDXW'(c % NREQ), 1'b0}) begin
        n_fail++;
        $display("FAIL rr_out c%0d: got v=%b d=%h g=%0d u=%b want 1 f %0d 0",
                 c, o_valid, o_data, o_grant, o_unknown, c % NREQ);
      end
    end
  endtask

  task automatic test_mask();
    logic [W-1:0] pat;
    pat = 4'b1x01;
    valid = 4'b0100; data = '0; data[2*W +: W] = pat; out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      en = '0; en[2] = c[0];
      #2;
      n_tests++;
      if (rdy !== exp_ready()) begin
        n_fail++; $display("FAIL mask_ready en=%0d: got %b want %b", c, rdy, exp_ready());
      end
      tick();
      n_tests++;
      if ({o_valid, o_data, o_grant, o_unknown} !== {m_valid, m_data, m_grant, m_unknown}) begin
        n_fail++;
        $display("FAIL mask_out en=%0d: got d=%b u=%b g=%0d want d=%b u=%b g=%0d",
                 c, o_data, o_unknown, o_grant, m_data, m_unknown, m_grant);
      end
    end
  endtask

  task automatic test_xvalid();
    valid = 4'b00x1; en = '1; data = 16'h1234; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #2;
      n_tests++;
      if (rdy !== exp_ready()) begin
        n_fail++; $display("FAIL xvalid_ready c%0d: got %b want %b", c, rdy, exp_ready());
      end
      tick();
      n_tests++;
      if ({o_valid, o_grant, o_data, o_xseen} !== {m_valid, m_grant, m_data, m_xseen}) begin
        n_fail++;
        $display("FAIL xvalid_out c%0d: got g=%0d d=%h xs=%b want g=%0d d=%h xs=%b",
                 c, o_grant, o_data, o_xseen, m_grant, m_data, m_xseen);
      end
    end
  endtask

  task automatic test_stall();
    valid = 4'b1011; en = 4'b0110; data = 16'h9C5A; out_ready = 1'b1;
    tick();
    for (int c = 0; c < 5; c++) begin
      out_ready = (c < 3) ? 1'b0 : (c == 3) ? 1'bx : 1'b1;
      if (c == 4) out_ready = 1'b1;
      if (c == 3) out_ready = 1'b0;
      #2;
      n_tests++;
      if (rdy !== exp_ready()) begin
        n_fail++; $display("FAIL stall_ready c%0d: got %b want %b", c, rdy, exp_ready());
      end
      tick();
      n_tests++;
      if ({o_valid, o_data, o_grant, o_unknown} !== {m_valid, m_data, m_grant, m_unknown}) begin
        n_fail++;
        $display("FAIL stall_out c%0d: got v=%b d=%h g=%0d want v=%b d=%h g=%0d",
                 c, o_valid, o_data, o_grant, m_valid, m_data, m_grant);
      end
    end
  endtask

  task automatic test_sticky();
    valid = 4'b0010; en = '1; data = '0; out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) test_reset();
      valid = 4'b0010; en = '1; out_ready = 1'b1;
      data = '0; data[W +: W] = (c == 0) ? 4'bx000 : 4'b0101;
      tick();
      n_tests++;
      if ({o_valid, o_data, o_unknown} !== {m_valid, m_data, m_unknown}) begin
        n_fail++;
        $display("FAIL sticky c%0d: got d=%b u=%b want d=%b u=%b",
                 c, o_data, o_unknown, m_data, m_unknown);
      end
    end
  endtask

  task automatic test_reset_mid();
    valid = '1; en = '1; data = 16'hA5C3; out_ready = 1'b0;
    tick();
    tick();
    test_reset();
  endtask

  task automatic test_random();
    int r;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        r = $urandom_range(0, 19);
        valid[i] = (r < 9) ? 1'b1 : (r == 19) ? 1'bx : 1'b0;
        r = $urandom_range(0, 9);
        en[i] = (r < 5) ? 1'b1 : (r == 9) ? 1'bx : 1'b0;
      end
      data = NREQ*W'($urandom);
      for (int b = 0; b < NREQ*W; b++)
        if ($urandom_range(0, 15) == 0) data[b] = 1'bx;
      r = $urandom_range(0, 9);
      out_ready = (r < 6) ? 1'b1 : (r == 9) ? 1'bx : 1'b0;
      #2;
      n_tests++;
      if (rdy !== exp_ready()) begin
        n_fail++; $display("FAIL rand_ready c%0d: got %b want %b", c, rdy, exp_ready());
      end
      tick();
      n_tests++;
      if ({o_valid, o_data, o_grant, o_unknown, o_xseen} !==
          {m_valid, m_data, m_grant, m_unknown, m_xseen}) begin
        n_fail++;
        $display("FAIL rand_out c%0d: got v=%b d=%b g=%0d u=%b xs=%b want v=%b d=%b g=%0d u=%b xs=%b",
                 c, o_valid, o_data, o_grant, o_unknown, o_xseen,
                 m_valid, m_data, m_grant, m_unknown, m_xseen);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_rr();
    test_mask();
    test_reset();
    test_xvalid();
    test_reset();
    test_stall();
    test_reset_mid();
    test_sticky();
    test_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/xprop_rr_sched.md
Name: xprop_rr_sched

Overview:
- Round-robin scheduler sharing one X-aware masking datapath among NREQ requesters.
- Per transaction: masks the low data bits by an enable, forwards the MSB unmasked, and X-poisons the whole result if any result bit is unknown.
- Sits in the unknown-value cosim area as the sequencer that feeds and drains the masking datapath, with a one-entry registered output and valid/ready handshakes.

Parameters:
- NREQ, 4, number of requesters (2..16).
- W, 4, data width per requester (>=2).
- IDXW, $clog2(NREQ), width of grant index (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester valid.
- req_en  input  NREQ  per-requester mask enable.
- req_data  input  NREQ*W  requester i occupies bits [i*W +: W].
- req_ready  output  NREQ  one-hot accept; at most one bit high.
- out_valid  output  1  result register holds data.
- out_ready  input  1  consumer accepts result.
- out_data  output  W  masked result, or all-X when poisoned.
- out_grant  output  IDXW  index of the requester that produced out_data.
- out_unknown  output  1  result was poisoned.
- x_valid_seen  output  1  sticky: some req_valid bit was unknown.

Behaviour:
- Reset (async assert, sync deassert):
  - out_valid=0, out_data=0, out_grant=0, out_unknown=0, x_valid_seen=0.
  - RR pointer=0; req_ready=0.
- Eligibility:
  - Requester i is eligible when req_valid[i]===1.
  - If req_valid[i] is X/Z, it is never granted, and x_valid_seen is set on the next edge.
  - x_valid_seen clears only on reset.
- Arbitration:
  - Search starts at the RR pointer and scans upward with wrap; the first eligible requester wins.
  - can_accept = !out_valid || out_ready.
  - req_ready[g]=1 for winner g only when can_accept; all others 0.
  - req_ready is combinational from inputs and state.
- Accept (req_valid[g]&&req_ready[g] at an edge):
  - result[W-2:0] = req_data[g][W-2:0] & {W-1{req_en[g]}}.
  - result[W-1] = req_data[g][W-1].
  - If $isunknown(result): out_data<='x and out_unknown<=1; else out_data<=result and out_unknown<=0.
  - Also out_grant<=g, out_valid<=1, pointer<=(g+1) mod NREQ.
- Latency and throughput:
  - 1 cycle from accept to out_valid.
  - Full throughput of 1 result per cycle while out_ready=1.
- Drain:
  - out_valid&&out_ready with no new accept -> out_valid<=0.
  - out_data, out_grant and out_unknown hold their last values.
- Stall: while out_valid&&!out_ready, all req_ready=0 and the output registers hold.
- Simultaneous drain and accept: the output is replaced in the same edge and out_valid stays 1.
- Pointer:
  - Advances only on accept.
  - Wraps NREQ-1 -> 0.
  - Holds when no requester is eligible.
- An X on req_en or req_data never blocks a grant; it only affects poisoning.
  - Example: en=0 masks X low bits to 0, so no poison unless the MSB is X.
- out_ready X while out_valid=1: treated as 0 (stall).
- Reset mid-operation: the pending result is discarded and all state returns to reset values immediately.

Optional Feature:
- XPROP_RR_STICKY_POISON_EN.
- Defined:
  - A per-requester sticky poison bit is set when that requester produces an unknown result.
  - While set, every later result from that requester is forced to out_data='x, out_unknown=1, regardless of its data.
  - Sticky bits clear only on reset.
- Undefined: each result is poisoned purely on its own value; no poison state is kept.

Test Plan:
- Reset then idle, all req_valid=0 -> out_valid=0, req_ready=0, out_data=0, pointer stays 0.
- NREQ=4; req_valid=4'b1111, data_i=4'hF, en=1, out_ready=1 held:
  - grants go 0,1,2,3,0 on consecutive cycles;
  - out_data=4'hF each cycle;
  - out_grant follows the grant sequence one cycle later.
- Requester 2 only, data=4'b1x01:
  - en=0 -> out_data=4'b1000, out_unknown=0;
  - en=1 -> out_data=4'bxxxx, out_unknown=1.
- req_valid=4'b00x1 -> only requester 0 is ever granted, and x_valid_seen=1 from the next edge.
- out_ready=0 for 3 cycles with out_valid=1 -> req_ready=0 and out_data stable; then out_ready=1 -> the next grant is accepted on that same edge.
- With XPROP_RR_STICKY_POISON_EN: requester 1 sends 4'bx000 then 4'b0101 -> both results are 4'bxxxx with out_unknown=1; after rst_n pulse, 4'b0101 -> 4'b0101.
